alu_arbiter: RTL

//  Shares one 16-bit ALU (ops AND/OR/XOR/arith, flags C V N Z) between two requesters.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-side signals of the shared ALU arbiter
interface alu_arbiter_if #(
  parameter int W   = 16,
  parameter int OPW = 3
);
  logic           r0_valid;
  logic           r0_ready;
  logic [W-1:0]   r0_a;
  logic [W-1:0]   r0_b;
  logic [OPW-1:0] r0_op;
  logic           r1_valid;
  logic           r1_ready;
  logic [W-1:0]   r1_a;
  logic [W-1:0]   r1_b;
  logic [OPW-1:0] r1_op;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [W-1:0]   rsp_y;
  logic [3:0]     rsp_flags;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_y;
  logic           alu_c;
  logic           alu_v;
  logic           alu_n;
  logic           alu_z;

  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    output r1_valid, r1_a, r1_b, r1_op,
    output rsp0_ready, rsp1_ready,
    output alu_y, alu_c, alu_v, alu_n, alu_z,
    input  r0_ready, r1_ready, rsp0_valid, rsp1_valid,
    input  rsp_y, rsp_flags, busy, alu_a, alu_b, alu_op
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    input  r1_valid, r1_a, r1_b, r1_op,
    input  rsp0_ready, rsp1_ready,
    input  alu_y, alu_c, alu_v, alu_n, alu_z,
    output r0_ready, r1_ready, rsp0_valid, rsp1_valid,
    output rsp_y, rsp_flags, busy, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_arbiter #(
  parameter int W   = 16,
  parameter int OPW = 3,
  parameter int LAT = 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_CNT = CW'(LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [OPW-1:0] op_q;
  logic           owner;
  logic           last_grant;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   y_q;
  logic [3:0]     flags_q;
  logic           gnt0;
  logic           gnt1;
  logic           capture;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grants are suppressed while rst is high so no request is acknowledged and then dropped.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          gnt0 = bus.r0_valid & (~bus.r1_valid | last_grant);
          gnt1 = bus.r1_valid & (~bus.r0_valid | ~last_grant);
        end
        if (gnt0 | gnt1) state_nxt = EXEC;
      end
      EXEC: begin
        capture = (cnt == CW'(1));
        if (capture) state_nxt = RESP;
      end
      RESP: begin
        if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      y_q        <= '0;
      flags_q    <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        a_q        <= gnt1 ? bus.r1_a  : bus.r0_a;
        b_q        <= gnt1 ? bus.r1_b  : bus.r0_b;
        op_q       <= gnt1 ? bus.r1_op : bus.r0_op;
        owner      <= gnt1;
        last_grant <= gnt1;
        cnt        <= LAT_CNT;
      end
      if (state == EXEC) cnt <= cnt - 1'b1;
      if (capture) begin
        y_q     <= bus.alu_y;
        flags_q <= {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_z};
      end
    end
  end

  // ALU operands come straight from the latch so they never glitch between ops.
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.r0_ready   = gnt0;
  assign bus.r1_ready   = gnt1;
  assign bus.rsp0_valid = (state == RESP) & ~owner;
  assign bus.rsp1_valid = (state == RESP) & owner;
  assign bus.rsp_y      = y_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.busy       = (state != IDLE);
endmodule
